// File: rtl/serial_id_reader_if.sv
// Bus bundle for serial_id_reader: host handshake, parallel result and the
// CLE320 serial-ID responder strobes.
interface serial_id_reader_if #(
    parameter int NBITS = 32
);
    logic             start;
    logic             abort;
    logic             busy;
    logic             done;
    logic             err;
    logic [NBITS-1:0] data;
    logic             sser_n;
    logic             ba13;
    logic             ba12;
    logic [3:0]       ba_nib;
    logic             br_w;
    logic             sclk;
    logic             sdrd;

    // reader side
    modport master (
        input  start, abort, sdrd,
        output busy, done, err, data, sser_n, ba13, ba12, ba_nib, br_w, sclk
    );

    // host / responder side
    modport slave (
        output start, abort, sdrd,
        input  busy, done, err, data, sser_n, ba13, ba12, ba_nib, br_w, sclk
    );
endinterface

// File: rtl/serial_id_reader.sv
// serial_id_reader: bus-side initiator for the CLE320 serial-ID responder.
// Drives the select strobes and responder clock, sends CMD_LEN unlock nibbles,
// then clocks NBITS bits from sdrd (LSB first) into a parallel word.
// Optional feature macro DOUBLE_READ_EN: a second full unlock+read after a
// one-step deselect gap; err flags a mismatch between the two reads.
module serial_id_reader #(
    parameter int                  NBITS   = 32,
    parameter int                  DIV     = 4,
    parameter int                  CMD_LEN = 4,
    parameter logic [4*CMD_LEN-1:0] UNLOCK = 16'hA9A2
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_id_reader_if.master bus
);
    localparam int DW   = $clog2(DIV);
    localparam int SMAX = (NBITS > CMD_LEN) ? NBITS : CMD_LEN;
    localparam int SW   = $clog2(SMAX);

`ifdef DOUBLE_READ_EN
    typedef enum logic [2:0] {S_IDLE, S_CMD, S_READ, S_DONE, S_GAP, S_CMD2, S_READ2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_CMD, S_READ, S_DONE} state_t;
`endif

    state_t            state, state_n;
    logic [DW-1:0]     div_cnt, div_n;
    logic [SW-1:0]     step_cnt, step_n;
    logic              step_end, xfer, last_cmd, last_bit, sample;
    logic              cmd_n, sel_n, busy_n, sclk_n;
    logic [3:0]        nib_n;
    logic [NBITS-1:0]  shreg;
`ifdef DOUBLE_READ_EN
    logic [NBITS-1:0]  first_rd;
`endif

    // State and step-timer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            div_cnt  <= '0;
            step_cnt <= '0;
        end else begin
            state    <= state_n;
            div_cnt  <= div_n;
            step_cnt <= step_n;
        end
    end

    // Next state, step timer and step counter
    always_comb begin
        state_n  = state;
        div_n    = div_cnt;
        step_n   = step_cnt;
        xfer     = (state != S_IDLE) && (state != S_DONE);
        step_end = (div_cnt == DW'(DIV - 1));
        last_cmd = (step_cnt == SW'(CMD_LEN - 1));
        last_bit = (step_cnt == SW'(NBITS - 1));
        sample   = 1'b0;
        if (xfer) div_n = step_end ? '0 : div_cnt + 1'b1;
        case (state)
            S_IDLE:  if (bus.start) state_n = S_CMD;
            S_CMD:   if (step_end && last_cmd) state_n = S_READ;
`ifdef DOUBLE_READ_EN
            S_READ:  if (step_end && last_bit) state_n = S_GAP;
            S_GAP:   if (step_end) state_n = S_CMD2;
            S_CMD2:  if (step_end && last_cmd) state_n = S_READ2;
            S_READ2: if (step_end && last_bit) state_n = S_DONE;
`else
            S_READ:  if (step_end && last_bit) state_n = S_DONE;
`endif
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (xfer && step_end) step_n = (state_n != state) ? '0 : step_cnt + 1'b1;
        if (state == S_READ) sample = (div_cnt == DW'(DIV / 2 - 1));
`ifdef DOUBLE_READ_EN
        if (state == S_READ2) sample = (div_cnt == DW'(DIV / 2 - 1));
`endif
        // abort overrides any step end that lands in the same cycle
        if (xfer && bus.abort) begin
            state_n = S_IDLE;
            div_n   = '0;
            step_n  = '0;
            sample  = 1'b0;
        end
    end

    // Next values of the registered bus outputs, derived from the next state
    always_comb begin
        cmd_n  = (state_n == S_CMD);
        sel_n  = (state_n == S_CMD) || (state_n == S_READ);
        busy_n = sel_n;
`ifdef DOUBLE_READ_EN
        cmd_n  = cmd_n || (state_n == S_CMD2);
        sel_n  = sel_n || (state_n == S_CMD2) || (state_n == S_READ2);
        busy_n = sel_n || (state_n == S_GAP);
`endif
        sclk_n = busy_n && (div_n >= DW'(DIV / 2));
        nib_n  = '0;
        if (cmd_n) begin
            for (int unsigned k = 0; k < unsigned'(CMD_LEN); k++) begin
                if (step_n == SW'(k)) nib_n = UNLOCK[4*k +: 4];
            end
        end
    end

    // Registered outputs; data/err only change on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.err    <= 1'b0;
            bus.data   <= '0;
            bus.sser_n <= 1'b1;
            bus.ba13   <= 1'b1;
            bus.ba12   <= 1'b0;
            bus.ba_nib <= '0;
            bus.br_w   <= 1'b1;
            bus.sclk   <= 1'b0;
        end else begin
            bus.busy   <= busy_n;
            bus.done   <= (state_n == S_DONE);
            bus.sser_n <= !sel_n;
            bus.ba13   <= !sel_n;
            bus.ba12   <= sel_n;
            bus.ba_nib <= nib_n;
            bus.br_w   <= 1'b1;
            bus.sclk   <= sclk_n;
            if (state_n == S_DONE) begin
`ifdef DOUBLE_READ_EN
                bus.data <= first_rd;
                bus.err  <= (first_rd != shreg);
`else
                bus.data <= shreg;
                bus.err  <= 1'b0;
`endif
            end
        end
    end

    // Serial capture: LSB-first shift, cleared on start and abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
`ifdef DOUBLE_READ_EN
            first_rd <= '0;
`endif
        end else if (xfer && bus.abort) begin
            shreg <= '0;
        end else if (state == S_IDLE && bus.start) begin
            shreg <= '0;
`ifdef DOUBLE_READ_EN
        end else if (state == S_READ && state_n == S_GAP) begin
            first_rd <= shreg;
            shreg    <= '0;
`endif
        end else if (sample) begin
            shreg <= {bus.sdrd, shreg[NBITS-1:1]};
        end
    end
endmodule

// File: tb/tb_serial_id_reader.sv
// Testbench for serial_id_reader: table of directed transactions against a
// behavioural CLE320 responder, plus back-to-back and mid-transaction reset.
// Honours DOUBLE_READ_EN (second read flips bit 7 when requested).
`timescale 1ns/1ps
module tb_serial_id_reader;
    localparam int NBITS   = 32;
    localparam int DIV     = 4;
    localparam int CMD_LEN = 4;
    localparam logic [15:0] UNLOCK = 16'hA9A2;
`ifdef DOUBLE_READ_EN
    localparam int DBL = 1;
`else
    localparam int DBL = 0;
`endif
    localparam int ONE  = (CMD_LEN + NBITS) * DIV;
    localparam int LAT  = (DBL != 0) ? 2 * ONE + DIV + 1 : ONE + 1;
    localparam int HOLD = 2 * LAT + 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    serial_id_reader_if #(.NBITS(NBITS)) bus ();

    serial_id_reader #(
        .NBITS(NBITS), .DIV(DIV), .CMD_LEN(CMD_LEN), .UNLOCK(UNLOCK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int nvec  = 0;
    int nfail = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Responder model (driven by bench, observed counters read by the test)
    logic [NBITS-1:0] word_r  = '0;
    logic             flip_r  = 1'b0;
    int               rd_base = 0;
    int  rd_num = 0, rd_rises = 0, tot_rises = 0, low_total = 0;
    int  last_low = 0, last_fall = 0, strobe_viol = 0;
    logic       prev_sclk = 1'b0, prev_sser = 1'b1;
    logic [3:0] prev_nib = '0;
    logic [3:0] nib_log [CMD_LEN];

    always @(negedge clk) begin
        logic [NBITS-1:0] w;
        int idx;
        if (bus.sclk && !prev_sclk && !bus.sser_n) begin
            if (bus.ba_nib != prev_nib || bus.sser_n != prev_sser) strobe_viol++;
            if (rd_rises < CMD_LEN) nib_log[rd_rises] = bus.ba_nib;
            rd_rises++;
            tot_rises++;
        end
        if (!bus.sser_n) begin
            low_total++;
            last_low = cyc;
            if (prev_sser) last_fall = cyc;
        end
        if (bus.sser_n) rd_rises = 0;
        if (bus.sser_n && !prev_sser) rd_num++;
        prev_sclk = bus.sclk;
        prev_sser = bus.sser_n;
        prev_nib  = bus.ba_nib;
        w = ((rd_num - rd_base) == 1 && flip_r) ? (word_r ^ NBITS'(32'h80)) : word_r;
        idx = rd_rises - CMD_LEN;
        bus.sdrd = (idx >= 0 && idx < NBITS) ? w[idx] : 1'b0;
    end

    typedef struct {
        logic [NBITS-1:0] word;
        logic             flip;
        int               abort_at;
        logic             exp_done;
        logic [NBITS-1:0] exp_data;
        logic             exp_err;
    } vec_t;

    vec_t       vt [9];
    logic [3:0] exp_nib [CMD_LEN];
    int c0, rises0, low0, viol0;

    task automatic run_txn(input logic [NBITS-1:0] w, input logic f, input int abort_at,
                           output logic got, output int at);
        @(posedge clk); #1;
        word_r = w; flip_r = f; rd_base = rd_num; c0 = cyc;
        rises0 = tot_rises; low0 = low_total; viol0 = strobe_viol;
        got = 1'b0; at = -1;
        bus.start = 1'b1;
        for (int k = 1; k <= LAT + 8; k++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            bus.abort = (k == abort_at);
            if (k == 1) begin
                chk("sel_sser_n", bus.sser_n, 0);
                chk("sel_ba13", bus.ba13, 0);
                chk("sel_ba12", bus.ba12, 1);
                chk("sel_br_w", bus.br_w, 1);
                chk("sel_busy", bus.busy, 1);
                chk("first_nib", bus.ba_nib, UNLOCK[3:0]);
            end
            if (abort_at > 0 && k == abort_at + 1) begin
                chk("abort_busy", bus.busy, 0);
                chk("abort_sser_n", bus.sser_n, 1);
            end
            if (bus.done && !got) begin
                got = 1'b1;
                at  = k;
            end
        end
        bus.abort = 1'b0;
    endtask

    initial begin
        logic got;
        int   at, d1, d2;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_data", bus.data, 0);
        chk("rst_sser_n", bus.sser_n, 1);
        chk("rst_ba13", bus.ba13, 1);
        chk("rst_ba12", bus.ba12, 0);
        chk("rst_ba_nib", bus.ba_nib, 0);
        chk("rst_br_w", bus.br_w, 1);
        chk("rst_sclk", bus.sclk, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        exp_nib = '{4'h2, 4'hA, 4'h9, 4'hA};
        vt[0] = '{32'hC3A5_0F96, 1'b0, 0,       1'b1, 32'hC3A5_0F96, 1'b0};
        vt[1] = '{32'h0000_0001, 1'b0, 0,       1'b1, 32'h0000_0001, 1'b0};
        vt[2] = '{32'h8000_0000, 1'b0, 0,       1'b1, 32'h8000_0000, 1'b0};
        vt[3] = '{32'hFFFF_FFFF, 1'b0, 0,       1'b1, 32'hFFFF_FFFF, 1'b0};
        vt[4] = '{32'h1234_5678, 1'b0, 60,      1'b0, 32'hFFFF_FFFF, 1'b0};
        vt[5] = '{32'h0F0F_F0F0, 1'b0, 1,       1'b0, 32'hFFFF_FFFF, 1'b0};
        vt[6] = '{32'h5A3C_96E1, 1'b0, LAT - 1, 1'b0, 32'hFFFF_FFFF, 1'b0};
        vt[7] = '{32'hA5A5_5A5A, 1'b1, 0,       1'b1, 32'hA5A5_5A5A, 1'(DBL)};
        vt[8] = '{32'h0F0F_F0F0, 1'b0, 0,       1'b1, 32'h0F0F_F0F0, 1'b0};

        for (int i = 0; i < 9; i++) begin
            run_txn(vt[i].word, vt[i].flip, vt[i].abort_at, got, at);
            chk("done_seen", got, vt[i].exp_done);
            if (vt[i].exp_done) chk("latency", at, LAT);
            chk("data", bus.data, vt[i].exp_data);
            chk("err", bus.err, vt[i].exp_err);
            chk("busy_end", bus.busy, 0);
            chk("sser_n_end", bus.sser_n, 1);
            if (vt[i].exp_done) begin
                chk("sclk_rises", tot_rises - rises0, (CMD_LEN + NBITS) * (1 + DBL));
                chk("sel_cycles", low_total - low0, ONE * (1 + DBL));
                chk("last_sel_cycle", last_low - c0, LAT - 1);
                chk("first_sel_cycle", last_fall - c0, 1 + DBL * (ONE + DIV));
                chk("strobe_stable", strobe_viol - viol0, 0);
                for (int j = 0; j < CMD_LEN; j++) chk("unlock_nib", nib_log[j], exp_nib[j]);
            end
        end

        // start held high: back-to-back transactions, start ignored in DONE
        @(posedge clk); #1;
        word_r = 32'hC3A5_0F96; flip_r = 1'b0; rd_base = rd_num;
        bus.start = 1'b1;
        d1 = -1; d2 = -1;
        for (int k = 1; k <= HOLD + 2; k++) begin
            @(posedge clk); #1;
            if (k == HOLD) begin
                bus.start = 1'b0;
                bus.abort = 1'b1;
            end else begin
                bus.abort = 1'b0;
            end
            if (k == LAT + 1) chk("b2b_idle_gap", bus.busy, 0);
            if (k == LAT + 2) chk("b2b_restart", bus.busy, 1);
            if (k == HOLD + 1) chk("b2b_abort", bus.busy, 0);
            if (bus.done) begin
                if (d1 < 0) d1 = k;
                else if (d2 < 0) d2 = k;
            end
        end
        chk("b2b_done1", d1, LAT);
        chk("b2b_done2", d2, 2 * LAT + 1);
        chk("b2b_data", bus.data, 32'hC3A5_0F96);

        // asynchronous reset in the middle of a read, with sclk high
        @(posedge clk); #1;
        bus.start = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        chk("pre_rst_sclk", bus.sclk, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sclk", bus.sclk, 0);
        chk("mid_rst_sser_n", bus.sser_n, 1);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_data", bus.data, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_txn(32'h5A3C_96E1, 1'b0, 0, got, at);
        chk("post_rst_done", got, 1);
        chk("post_rst_latency", at, LAT);
        chk("post_rst_data", bus.data, 32'h5A3C_96E1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
